// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller and the ALU control unit:
// state encoding, opcode values, datapath select codes and the control bundle.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W     = 4;
    localparam int unsigned OPCODE_W    = 6;
    localparam int unsigned ALU_OP_W    = 2;
    localparam int unsigned PC_SRC_W    = 2;
    localparam int unsigned ALU_SRC_B_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b10;

    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [ALU_SRC_B_W-1:0] SRC_B_REG     = 2'b00;
    localparam logic [ALU_SRC_B_W-1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [ALU_SRC_B_W-1:0] SRC_B_IMM     = 2'b10;
    localparam logic [ALU_SRC_B_W-1:0] SRC_B_IMM_SH2 = 2'b11;

    // Datapath control bundle driven by the output decoder.
    typedef struct packed {
        logic                   pc_write;
        logic                   pc_write_cond;
        logic                   i_or_d;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   ir_write;
        logic                   alu_src_a;
        logic                   reg_write;
        logic                   reg_dst;
        logic [PC_SRC_W-1:0]    pc_source;
        logic [ALU_SRC_B_W-1:0] alu_src_b;
        logic [ALU_OP_W-1:0]    alu_op;
        logic                   instr_done;
        logic                   illegal_op;
    } ctrl_t;

    // True for opcodes the controller knows how to sequence.
    function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Output decoder: maps the current state (plus mem_ready for the handshake
// strobes and opcode for the illegal flag) to the datapath control bundle.
// Ports: state, mem_ready, opcode in; enable (low forces all strobes off);
// ctrl out.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t                state,
    input  logic                  mem_ready,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  enable,
    output ctrl_t                 ctrl
);

    // Per-state strobes; anything not set stays 0, so unused codes are inert.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                // PC and IR update only on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRC_B_IMM_SH2;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.illegal_op = ~op_supported(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // Held in reset: FETCH must not issue a read or advance the PC.
        if (!enable) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle processor main controller (Moore FSM).
// Ports: clk, rst_n (async active-low); opcode (IR[31:26]), mem_ready in;
// datapath strobes/selects, state, instr_done, illegal_op out.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPCODE_W-1:0]    opcode,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem_to_reg,
    output logic                   ir_write,
    output logic                   alu_src_a,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic [PC_SRC_W-1:0]    pc_source,
    output logic [ALU_SRC_B_W-1:0] alu_src_b,
    output logic [ALU_OP_W-1:0]    alu_op,
    output logic [STATE_W-1:0]     state,
    output logic                   instr_done,
    output logic                   illegal_op
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode is looked at only in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .enable    (rst_n),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: opcode  in  6  instruction bits [31:26] from IR; mem_ready  in  1  memory access complete this cycle.
REQ-003 SHALL have ports: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst  out  1 each  datapath strobes/selects.
REQ-004 SHALL have ports: pc_source  out  2  (00 ALU, 01 ALUOut, 10 jump target); alu_src_b  out  2  (00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2); alu_op  out  2  to ALU control (00 add, 10 sub, 01 use funct).
REQ-005 SHALL have ports: state  out  4  current state; instr_done  out  1  last cycle of an instruction; illegal_op  out  1  unsupported opcode pulse.

Function
REQ-006 SHALL be a Moore FSM; every output SHALL depend only on state, except strobes gated by mem_ready (REQ-010).
REQ-007 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11; codes 12-15 SHALL return to FETCH next cycle with all strobes 0.
REQ-008 Transitions: FETCH->DECODE when mem_ready; DECODE by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->FETCH; MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB when mem_ready; MEMWR->FETCH when mem_ready; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-009 opcode SHALL be sampled only in DECODE and MEMADR; changes at other times ignored.
REQ-010 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL equal mem_ready (PC increments exactly once per fetch regardless of wait cycles).
REQ-011 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. MEMADR/ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-012 MEMRD: mem_read=1, i_or_d=1. MEMWR: mem_write=1, i_or_d=1 held for every wait cycle. MEMWB: reg_write=mem_ready-independent 1, mem_to_reg=1, reg_dst=0.
REQ-013 EXEC: alu_src_a=1, alu_src_b=00, alu_op=01. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=10, pc_write_cond=1, pc_source=01. JUMP: pc_write=1, pc_source=10.
REQ-015 Any output not listed for a state SHALL be 0; alu_op SHALL never be 11 or X/Z.
REQ-016 instr_done SHALL be 1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR when mem_ready=1.
REQ-017 illegal_op SHALL be 1 for exactly the DECODE cycle holding an unsupported opcode.
REQ-018 Latencies with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-019 rst_n=0 SHALL force state=FETCH immediately (asynchronously), mid-instruction included; all registered outputs 0.
REQ-020 During reset, combinational FETCH outputs SHALL be suppressed (pc_write, ir_write, mem_read = 0); first fetch begins on the first rising edge after rst_n deasserts.

Structure
REQ-021 Package mc_ctrl_pkg SHALL hold the state enum, opcode constants and ALUOp/pc_source/alu_src_b constants, shared with the ALU control unit.
REQ-022 One sub-module mc_ctrl_outdec SHALL map state (+mem_ready) to outputs; mc_ctrl_fsm holds state register and next-state logic.

Verification
REQ-023 Reset then mem_ready=1, opcode=000000 -> states 0,1,6,7,0; alu_op 00,00,01,00; reg_write/reg_dst=1 in state 7; instr_done once.
REQ-024 lw (100011) with mem_ready low 2 cycles in FETCH and MEMRD -> pc_write exactly 1 cycle; 9 total cycles; mem_to_reg=1 in MEMWB.
REQ-025 beq (000100) -> state 8 with alu_op=10, pc_write_cond=1, pc_source=01; j (000010) -> pc_write=1, pc_source=10.
REQ-026 opcode=111111 -> illegal_op pulse in DECODE, next state FETCH, no reg_write/mem_write.
REQ-027 rst_n low mid-MEMWR -> state 0 same cycle, mem_write drops without clock edge.
